fx_mul: RTL and testbench

FX_MUL -- requirements
Module: fx_mul

---
 rtl/fx_mul.sv | 158 +++++++++++++++
 tb/tb_fx_mul.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fx_mul.sv
// fx_mul: sequential shift-add multiplier of an unsigned fixed-point
// multiplicand by an unsigned integer multiplier, with saturation and rounding.
//
// Parameters:
//   IN_W  integer operand width
//   P     fractional bits of the fixed-point operand/result
//
// Ports:
//   clk    sole clock, rising edge
//   rst    synchronous active-high reset
//   start  request, sampled only while idle
//   a      multiplicand, IN_W integer bits + P fractional bits
//   b      integer multiplier, IN_W bits
//   p      saturated fixed-point product (same format as a)
//   p_int  product rounded half-up to an integer, saturated
//   ovf    product did not fit in IN_W+P bits
//   busy   operation in progress (RUN or FIN)
//   done   one-cycle completion pulse
//
// Timing: start-sampling edge -> IN_W RUN edges -> FIN edge raising done,
// i.e. IN_W+1 edges of latency regardless of operand values.
module fx_mul #(
    parameter int IN_W = 16,
    parameter int P    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IN_W+P-1:0]  a,
    input  logic [IN_W-1:0]    b,
    output logic [IN_W+P-1:0]  p,
    output logic [IN_W-1:0]    p_int,
    output logic               ovf,
    output logic               busy,
    output logic               done
);

    localparam int PW    = IN_W + P;
    localparam int ACC_W = 2 * IN_W + P;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    // Half an LSB of the integer part, added before truncation to round half up.
    localparam logic [PW:0] HALF = (PW + 1)'(1) << (P - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state_reg,  state_next;
    logic [ACC_W-1:0]    acc_reg,    acc_next;
    logic [ACC_W-1:0]    mcand_reg,  mcand_next;
    logic [IN_W-1:0]     mplier_reg, mplier_next;
    logic [CNT_W-1:0]    cnt_reg,    cnt_next;
    logic [PW-1:0]       p_reg,      p_next;
    logic [IN_W-1:0]     p_int_reg,  p_int_next;
    logic                ovf_reg,    ovf_next;
    logic                busy_reg,   busy_next;
    logic                done_reg,   done_next;

    // Result formatting from the finished accumulator.
    logic                res_ovf;
    logic [PW-1:0]       res_p;
    logic [PW:0]         rnd_sum;
    logic [IN_W:0]       rnd_int;
    logic [IN_W-1:0]     res_p_int;

    always_comb begin
        res_ovf   = |acc_reg[ACC_W-1:PW];
        res_p     = res_ovf ? '1 : acc_reg[PW-1:0];
        rnd_sum   = {1'b0, res_p} + HALF;
        rnd_int   = rnd_sum[PW:P];
        // A carry into bit IN_W means the rounded value no longer fits.
        res_p_int = (res_ovf || rnd_int[IN_W]) ? '1 : rnd_int[IN_W-1:0];
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        p_next      = p_reg;
        p_int_next  = p_int_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    mcand_next  = ACC_W'(a);
                    mplier_next = b;
                    acc_next    = '0;
                    cnt_next    = CNT_W'(IN_W - 1);
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (mplier_reg[0]) begin
                    acc_next = acc_reg + mcand_reg;
                end
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg - CNT_W'(1);
                if (cnt_reg == '0) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                p_next     = res_p;
                p_int_next = res_p_int;
                ovf_next   = res_ovf;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Registered busy tracks the state the machine is about to enter.
        busy_next = (state_next == RUN) || (state_next == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            p_reg      <= '0;
            p_int_reg  <= '0;
            ovf_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            p_reg      <= p_next;
            p_int_reg  <= p_int_next;
            ovf_reg    <= ovf_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign p     = p_reg;
    assign p_int = p_int_reg;
    assign ovf   = ovf_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_fx_mul.sv
// tb_fx_mul: directed + randomized checks of fx_mul against an arithmetic
// reference model (plain integer product, saturation, round half up).
module tb_fx_mul;

    localparam int IN_W = 16;
    localparam int P    = 8;
    localparam int PW   = IN_W + P;

    logic             clk;
    logic             rst;
    logic             start;
    logic [PW-1:0]    a;
    logic [IN_W-1:0]  b;
    logic [PW-1:0]    p;
    logic [IN_W-1:0]  p_int;
    logic             ovf;
    logic             busy;
    logic             done;

    int n_assert;
    int n_fail;

    fx_mul #(.IN_W(IN_W), .P(P)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .p     (p),
        .p_int (p_int),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: exact product, saturate to PW bits, then round half up.
    task automatic model(input logic [PW-1:0] av, input logic [IN_W-1:0] bv,
                         output logic [PW-1:0] ep, output logic [IN_W-1:0] epi,
                         output logic eo);
        longint unsigned prod;
        longint unsigned r;
        prod = longint'(av) * longint'(bv);
        eo   = (prod > 64'hFF_FFFF);
        ep   = eo ? 24'hFF_FFFF : prod[PW-1:0];
        r    = (longint'(ep) + 128) / 256;
        epi  = (eo || r > 65535) ? 16'hFFFF : r[IN_W-1:0];
    endtask

    // One operation: start sampled at edge 0; optional second start at inj_edge.
    task automatic do_op(input logic [PW-1:0] av, input logic [IN_W-1:0] bv,
                         input string tag, input int inj_edge);
        logic [PW-1:0]   ep;
        logic [IN_W-1:0] epi;
        logic            eo;
        int              lat;
        int              extra;
        model(av, bv, ep, epi, eo);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 24'($urandom);
        b = 16'($urandom);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (i == 1 || i == 16) chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (inj_edge > 0 && i == inj_edge - 1) begin
                start = 1'b1; a = 24'h000200; b = 16'd5;
            end
            if (inj_edge > 0 && i == inj_edge) start = 1'b0;
        end
        chk({tag, "_lat"},   32'(lat),   32'd17);
        chk({tag, "_p"},     32'(p),     32'(ep));
        chk({tag, "_pint"},  32'(p_int), 32'(epi));
        chk({tag, "_ovf"},   32'(ovf),   32'(eo));
        chk({tag, "_busy0"}, 32'(busy),  32'd0);
        $display("op %s a=%06h b=%04h p=%06h p_int=%04h ovf=%0d lat=%0d",
                 tag, av, bv, p, p_int, ovf, lat);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"},  32'(p),    32'(ep));
        if (inj_edge > 0) begin
            extra = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            chk({tag, "_nodone"}, 32'(extra), 32'd0);
            chk({tag, "_keep"},   32'(p),     32'(ep));
        end
    endtask

    initial begin
        int dcount;
        int last_d;
        logic [PW-1:0]   ra;
        logic [IN_W-1:0] rb;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p",    32'(p),     32'd0);
        chk("rst_pint", 32'(p_int), 32'd0);
        chk("rst_ovf",  32'(ovf),   32'd0);
        chk("rst_busy", 32'(busy),  32'd0);
        chk("rst_done", 32'(done),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(24'h000180, 16'd10, "x1p5_10", 0);
        do_op(24'h000080, 16'd3,  "half_3", 0);
        do_op(24'hFFFF00, 16'd2,  "ovf", 0);
        do_op(24'hFFFF80, 16'd1,  "rndsat", 0);
        do_op(24'h000100, 16'd0,  "b0_inj", 8);
        do_op(24'h000000, 16'hFFFF, "a0", 0);

        // Reset in the middle of RUN aborts without done.
        @(negedge clk);
        a = 24'h000300; b = 16'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy),  32'd0);
        chk("mid_done", 32'(done),  32'd0);
        chk("mid_p",    32'(p),     32'd0);
        chk("mid_pint", 32'(p_int), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        chk("mid_nodone", 32'(dcount), 32'd0);
        $display("op reset_mid_run dones_after=%0d", dcount);
        do_op(24'h000100, 16'd7, "after_rst", 0);

        // Randomized operations: full-range and small operands.
        for (int k = 0; k < 16; k++) begin
            if (k[0]) begin
                ra = 24'($urandom);
                rb = 16'($urandom);
            end else begin
                ra = 24'($urandom_range(0, 24'h00FFFF));
                rb = 16'($urandom_range(0, 255));
            end
            do_op(ra, rb, $sformatf("rnd%0d", k), 0);
        end

        // start held high: back-to-back done every 18 edges.
        @(negedge clk);
        a = 24'h000100; b = 16'd4; start = 1'b1;
        @(posedge clk);
        dcount = 0;
        last_d = 0;
        for (int i = 1; i <= 55; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dcount++;
                chk("b2b_gap", 32'(i - last_d), (last_d == 0) ? 32'd17 : 32'd18);
                chk("b2b_p",   32'(p),          32'h000400);
                $display("op b2b done at edge %0d p=%06h", i, p);
                last_d = i;
            end
        end
        chk("b2b_count", 32'(dcount), 32'd3);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_op(24'h000100, 16'd4, "post_b2b", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
